// File: rtl/bp_pkg.sv
// Shared types and helpers for the next-PC branch predictor.
// Holds the 2-bit PHT counter encoding and its saturating update rule.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Counter sticks at the strong states instead of wrapping.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t w_next;
    if (taken) begin
      w_next = (ctr == CTR_ST) ? CTR_ST : ctr_t'(2'(ctr + 2'd1));
    end else begin
      w_next = (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(2'(ctr - 2'd1));
    end
    return w_next;
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer: one combinational read port, one write port.
// Only the valid bits are cleared by reset or flush; tag and target are plain storage.
module btb_array #(
  parameter int ENTRIES  = 16,
  parameter int TAG_W    = 26,
  parameter int PC_WIDTH = 32,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [IW-1:0]       rd_idx,
  output logic                rd_valid,
  output logic                rd_uncond,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [PC_WIDTH-1:0] rd_target,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic                wr_uncond,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [PC_WIDTH-1:0] wr_target
);

  typedef struct packed {
    logic                valid;
    logic                uncond;
    logic [TAG_W-1:0]    tag;
    logic [PC_WIDTH-1:0] target;
  } btb_entry_t;

  btb_entry_t r_mem [ENTRIES];
  btb_entry_t w_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i].valid <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i].valid <= 1'b0;
    end else if (wr_en) begin
      r_mem[wr_idx] <= '{valid: 1'b1, uncond: wr_uncond, tag: wr_tag, target: wr_target};
    end
  end

  assign w_rd      = r_mem[rd_idx];
  assign rd_valid  = w_rd.valid;
  assign rd_uncond = w_rd.uncond;
  assign rd_tag    = w_rd.tag;
  assign rd_target = w_rd.target;

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB plus a 2-bit PHT, bimodal or gshare-indexed.
// Lookup is combinational from registered state; training arrives from EX, one per cycle.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int PHT_BITS    = 6,
  parameter int HIST_BITS   = 0,
  parameter int PC_WIDTH    = 32,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [PC_WIDTH-1:0]   pred_next_pc,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_uncond,
  input  logic                  upd_taken,
  input  logic [PC_WIDTH-1:0]   upd_target,
  input  logic                  upd_pred_taken,
  input  logic [PC_WIDTH-1:0]   upd_pred_target,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int IW     = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = PC_WIDTH - IW - 2;
  localparam int PHT_N  = 1 << PHT_BITS;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic                w_rd_valid;
  logic                w_rd_uncond;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [PC_WIDTH-1:0] w_rd_target;
  logic [PHT_BITS-1:0] w_ghr_ext;
  logic [PHT_BITS-1:0] w_lk_pht_idx;
  logic [PHT_BITS-1:0] w_up_pht_idx;
  logic                w_upd_en;
  logic                w_mispredict;
  logic                w_unused_upd_pc;

  ctr_t                  r_pht [PHT_N];
  logic [STAT_WIDTH-1:0] r_branch_count;
  logic [STAT_WIDTH-1:0] r_mispredict_count;

  // Flush has priority: an update arriving alongside it is dropped entirely.
  assign w_upd_en        = upd_valid & ~flush;
  assign w_unused_upd_pc = ^upd_pc[1:0];

  btb_array #(
    .ENTRIES  (BTB_ENTRIES),
    .TAG_W    (TAG_W),
    .PC_WIDTH (PC_WIDTH)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .rd_idx    (lookup_pc[IW+1:2]),
    .rd_valid  (w_rd_valid),
    .rd_uncond (w_rd_uncond),
    .rd_tag    (w_rd_tag),
    .rd_target (w_rd_target),
    .wr_en     (w_upd_en & upd_taken),
    .wr_idx    (upd_pc[IW+1:2]),
    .wr_uncond (upd_uncond),
    .wr_tag    (upd_pc[PC_WIDTH-1:IW+2]),
    .wr_target (upd_target)
  );

  generate
    if (HIST_BITS == 0) begin : g_bimodal
      assign w_ghr_ext = '0;
    end else begin : g_gshare
      logic [HIST_BITS-1:0] r_ghr;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_ghr <= '0;
        end else if (flush) begin
          r_ghr <= '0;
        end else if (upd_valid && !upd_uncond) begin
          r_ghr <= HIST_BITS'({r_ghr, upd_taken});
        end
      end

      assign w_ghr_ext = PHT_BITS'(r_ghr);
    end
  endgenerate

  assign w_lk_pht_idx = lookup_pc[PHT_BITS+1:2] ^ w_ghr_ext;
  assign w_up_pht_idx = upd_pc[PHT_BITS+1:2] ^ w_ghr_ext;

  assign pred_hit     = w_rd_valid && (w_rd_tag == lookup_pc[PC_WIDTH-1:IW+2]);
  assign pred_taken   = pred_hit && (w_rd_uncond || r_pht[w_lk_pht_idx][1]);
  assign pred_next_pc = pred_taken ? w_rd_target : lookup_pc + PC_WIDTH'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= CTR_WNT;
    end else if (flush) begin
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= CTR_WNT;
    end else if (upd_valid && !upd_uncond) begin
      r_pht[w_up_pht_idx] <= ctr_next(r_pht[w_up_pht_idx], upd_taken);
    end
  end

  assign w_mispredict = (upd_pred_taken != upd_taken) ||
                        (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));

  // Statistics survive flush and saturate rather than wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_upd_en) begin
      if (r_branch_count != STAT_MAX) r_branch_count <= r_branch_count + 1'b1;
      if (w_mispredict && (r_mispredict_count != STAT_MAX)) begin
        r_mispredict_count <= r_mispredict_count + 1'b1;
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: bimodal, gshare and narrow-statistics instances driven in lockstep.
// A table-level model (arrays of entries and integer counters) predicts every output.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] lookupPc;
  logic        updValid;
  logic [31:0] updPc;
  logic        updUncond;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updPredTaken;
  logic [31:0] updPredTarget;

  logic        hitB, takenB, hitG, takenG, hitS, takenS;
  logic [31:0] npcB, npcG, npcS;
  logic [15:0] bcB, mcB, bcG, mcG;
  logic [3:0]  bcS, mcS;

  int compared   = 0;
  int mismatched = 0;

  bit          mValid [3][16];
  bit          mUnc   [3][16];
  int unsigned mTag   [3][16];
  int unsigned mTgt   [3][16];
  int          mPht   [3][64];
  int          mGhr   [3];
  int          mBc    [3];
  int          mMc    [3];
  int          histBits [3] = '{0, 4, 0};
  int          statMax  [3] = '{65535, 65535, 15};

  always #5 clk = ~clk;

  branch_predictor dutB (
    .clk(clk), .reset(reset), .flush(flush), .lookup_pc(lookupPc),
    .pred_hit(hitB), .pred_taken(takenB), .pred_next_pc(npcB),
    .upd_valid(updValid), .upd_pc(updPc), .upd_uncond(updUncond), .upd_taken(updTaken),
    .upd_target(updTarget), .upd_pred_taken(updPredTaken), .upd_pred_target(updPredTarget),
    .branch_count(bcB), .mispredict_count(mcB)
  );

  branch_predictor #(.HIST_BITS(4)) dutG (
    .clk(clk), .reset(reset), .flush(flush), .lookup_pc(lookupPc),
    .pred_hit(hitG), .pred_taken(takenG), .pred_next_pc(npcG),
    .upd_valid(updValid), .upd_pc(updPc), .upd_uncond(updUncond), .upd_taken(updTaken),
    .upd_target(updTarget), .upd_pred_taken(updPredTaken), .upd_pred_target(updPredTarget),
    .branch_count(bcG), .mispredict_count(mcG)
  );

  branch_predictor #(.STAT_WIDTH(4)) dutS (
    .clk(clk), .reset(reset), .flush(flush), .lookup_pc(lookupPc),
    .pred_hit(hitS), .pred_taken(takenS), .pred_next_pc(npcS),
    .upd_valid(updValid), .upd_pc(updPc), .upd_uncond(updUncond), .upd_taken(updTaken),
    .upd_target(updTarget), .upd_pred_taken(updPredTaken), .upd_pred_target(updPredTarget),
    .branch_count(bcS), .mispredict_count(mcS)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 16; i++) mValid[c][i] = 1'b0;
      for (int i = 0; i < 64; i++) mPht[c][i] = 1;
      mGhr[c] = 0;
      mBc[c]  = 0;
      mMc[c]  = 0;
    end
  endtask

  task automatic modelPredict(input int c, input int unsigned pc,
                              output bit hit, output bit tk, output int unsigned npc);
    int idx  = int'((pc >> 2) % 16);
    int pIdx = int'((pc >> 2) % 64) ^ mGhr[c];
    hit = mValid[c][idx] && (mTag[c][idx] == (pc >> 6));
    tk  = hit && (mUnc[c][idx] || (mPht[c][pIdx] >= 2));
    npc = tk ? mTgt[c][idx] : pc + 4;
  endtask

  // Applies what the inputs present at a rising edge do to one configuration.
  task automatic modelUpdate(input int c);
    int  idx, pIdx;
    bit  mis;
    if (flush) begin
      for (int i = 0; i < 16; i++) mValid[c][i] = 1'b0;
      for (int i = 0; i < 64; i++) mPht[c][i] = 1;
      mGhr[c] = 0;
    end else if (updValid) begin
      mis = (updPredTaken != updTaken) || (updTaken && updPredTaken && updPredTarget != updTarget);
      if (mBc[c] < statMax[c]) mBc[c]++;
      if (mis && mMc[c] < statMax[c]) mMc[c]++;
      idx = int'((updPc >> 2) % 16);
      if (updTaken) begin
        mValid[c][idx] = 1'b1;
        mUnc[c][idx]   = updUncond;
        mTag[c][idx]   = updPc >> 6;
        mTgt[c][idx]   = updTarget;
      end
      if (!updUncond) begin
        pIdx = int'((updPc >> 2) % 64) ^ mGhr[c];
        if (updTaken) mPht[c][pIdx] = (mPht[c][pIdx] == 3) ? 3 : mPht[c][pIdx] + 1;
        else          mPht[c][pIdx] = (mPht[c][pIdx] == 0) ? 0 : mPht[c][pIdx] - 1;
        if (histBits[c] > 0) mGhr[c] = ((mGhr[c] << 1) | int'(updTaken)) % (1 << histBits[c]);
      end
    end
  endtask

  task automatic checkModel();
    bit          eHit, eTk;
    int unsigned eNpc;
    logic        oHit, oTk;
    logic [31:0] oNpc, oBc, oMc;
    for (int c = 0; c < 3; c++) begin
      modelPredict(c, lookupPc, eHit, eTk, eNpc);
      case (c)
        0:       begin oHit = hitB; oTk = takenB; oNpc = npcB; oBc = 32'(bcB); oMc = 32'(mcB); end
        1:       begin oHit = hitG; oTk = takenG; oNpc = npcG; oBc = 32'(bcG); oMc = 32'(mcG); end
        default: begin oHit = hitS; oTk = takenS; oNpc = npcS; oBc = 32'(bcS); oMc = 32'(mcS); end
      endcase
      checkOutput($sformatf("hit[%0d]", c), 32'(oHit), 32'(eHit));
      checkOutput($sformatf("taken[%0d]", c), 32'(oTk), 32'(eTk));
      checkOutput($sformatf("next_pc[%0d]", c), oNpc, eNpc);
      checkOutput($sformatf("branch_count[%0d]", c), oBc, 32'(mBc[c]));
      checkOutput($sformatf("mispredict_count[%0d]", c), oMc, 32'(mMc[c]));
    end
  endtask

  // Drives one cycle of inputs, checks lookup against pre-edge state, then advances the model.
  task automatic applyStimulus(input bit fl, input bit uv, input int unsigned pc, input bit unc,
                               input bit tk, input int unsigned tgt, input bit ptk,
                               input int unsigned ptgt, input int unsigned lpc);
    flush = fl; updValid = uv; updPc = pc; updUncond = unc; updTaken = tk;
    updTarget = tgt; updPredTaken = ptk; updPredTarget = ptgt; lookupPc = lpc;
    @(negedge clk);
    checkModel();
    @(posedge clk);
    for (int c = 0; c < 3; c++) modelUpdate(c);
    #1;
  endtask

  task automatic lookupOnly(input int unsigned lpc);
    flush = 1'b0; updValid = 1'b0; lookupPc = lpc;
    #1;
    checkModel();
  endtask

  // Pulses reset between edges while an update is pending on the inputs.
  task automatic asyncReset();
    updValid = 1'b1; updPc = 32'h40; updTaken = 1'b1; updUncond = 1'b0; lookupPc = 32'h40;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    modelReset();
    checkModel();
    checkOutput("async_bc", 32'(bcS), 32'd0);
    checkOutput("async_hit", 32'(hitB), 32'd0);
    updValid = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned pc, lpc, tgt;
    reset = 1'b0; flush = 1'b0; updValid = 1'b0; updPc = '0; updUncond = 1'b0;
    updTaken = 1'b0; updTarget = '0; updPredTaken = 1'b0; updPredTarget = '0; lookupPc = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    lookupOnly(32'h40);
    checkOutput("reset_hit", 32'(hitB), 32'd0);
    checkOutput("reset_taken", 32'(takenB), 32'd0);
    checkOutput("reset_next_pc", npcB, 32'h44);
    checkOutput("reset_counts", {16'(bcB), 16'(mcB)}, 32'd0);

    $display("[TB] bimodal training");
    applyStimulus(0, 1, 32'h40, 0, 1, 32'h80, 0, 32'h44, 32'h40);
    lookupOnly(32'h40);
    checkOutput("bim_hit", 32'(hitB), 32'd1);
    checkOutput("bim_taken", 32'(takenB), 32'd1);
    checkOutput("bim_next_pc", npcB, 32'h80);
    checkOutput("bim_bc", 32'(bcB), 32'd1);
    checkOutput("bim_mc", 32'(mcB), 32'd1);
    repeat (2) applyStimulus(0, 1, 32'h40, 0, 1, 32'h80, 1, 32'h80, 32'h40);
    repeat (3) applyStimulus(0, 1, 32'h40, 0, 0, 32'h80, 1, 32'h80, 32'h40);
    lookupOnly(32'h40);
    checkOutput("bim_nt_taken", 32'(takenB), 32'd0);
    checkOutput("bim_nt_next_pc", npcB, 32'h44);

    $display("[TB] unconditional and aliasing");
    applyStimulus(0, 1, 32'h100, 1, 1, 32'h20, 0, 32'h104, 32'h100);
    lookupOnly(32'h100);
    checkOutput("unc_taken", 32'(takenB), 32'd1);
    checkOutput("unc_next_pc", npcB, 32'h20);
    applyStimulus(0, 1, 32'h440, 1, 1, 32'h10, 0, 32'h444, 32'h440);
    lookupOnly(32'h40);
    checkOutput("alias_miss", 32'(hitB), 32'd0);
    lookupOnly(32'h440);
    checkOutput("alias_next_pc", npcB, 32'h10);

    $display("[TB] gshare indexing");
    asyncReset();
    applyStimulus(0, 1, 32'h40, 0, 1, 32'h80, 0, 32'h44, 32'h40);
    lookupOnly(32'h40);
    checkOutput("gsh_hit", 32'(hitG), 32'd1);
    checkOutput("gsh_taken", 32'(takenG), 32'd0);
    checkOutput("gsh_bim_taken", 32'(takenB), 32'd1);

    $display("[TB] flush with update, same-cycle lookup/update");
    applyStimulus(1, 1, 32'h40, 0, 1, 32'h80, 0, 32'h44, 32'h40);
    lookupOnly(32'h40);
    checkOutput("flush_hit", 32'(hitB), 32'd0);
    checkOutput("flush_bc", 32'(bcB), 32'd1);
    checkOutput("flush_mc", 32'(mcB), 32'd1);
    applyStimulus(0, 1, 32'h40, 1, 1, 32'h80, 0, 32'h44, 32'h40);
    lookupOnly(32'h40);
    checkOutput("post_same_cycle_hit", 32'(hitB), 32'd1);

    $display("[TB] saturation");
    asyncReset();
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 32'(i * 4), 0, 1, 32'h200, 0, 32'h0, 32'h0);
    lookupOnly(32'h0);
    checkOutput("sat_mc", 32'(mcS), 32'd15);
    checkOutput("sat_bc", 32'(bcS), 32'd15);
    checkOutput("wide_bc", 32'(bcB), 32'd20);
    asyncReset();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 31) << 2);
      lpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 31) << 2);
      tgt = $urandom_range(0, 255) << 2;
      applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, pc,
                    $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), tgt,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? tgt : ($urandom_range(0, 255) << 2), lpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
